seg_frame_scanner: RTL and testbench
====================================

SEG_FRAME_SCANNER -- requirements
Module: seg_frame_scanner

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 4: newclock cycles each digit is driven; legal range 2..255.
REQ-002 SHALL have parameter BLINK_FRAMES, default 8: full scan frames per blink half-period; legal range 1..255.
REQ-003 SHALL have port newclock  input  1: clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port an_in  input  8: digit enable mask, bit k enables digit k (bit 7 = leftmost).
REQ-006 SHALL have port c_in  input  56: segment frame, digit k at c_in[7k+6:7k], order {g,f,e,d,c,b,a}, 1 = lit.
REQ-007 SHALL have port load  input  1: single-cycle strobe requesting capture of an_in/c_in.
REQ-008 SHALL have port blink_en  input  1: 1 = whole display blinks.
REQ-009 SHALL have port an_out  output  8: active-low anode drive, at most one bit low.
REQ-010 SHALL have port c_out  output  7: active-low cathode drive, {g..a}.
REQ-011 SHALL have port pending  output  1: captured frame awaiting transfer to active frame.
REQ-012 SHALL have port frame_done  output  1: one-cycle pulse at end of each full scan.

Function
REQ-013 Dwell counter SHALL count 0..DWELL_CYCLES-1, then wrap to 0 and advance digit index 0->1->...->7->0.
REQ-014 Frame boundary SHALL be the cycle where dwell counter = DWELL_CYCLES-1 and digit index = 7; frame_done SHALL pulse high on exactly that cycle.
REQ-015 Load with load=1 SHALL capture an_in/c_in into pending registers and set pending=1 next edge; a later load before transfer SHALL overwrite (last write wins).
REQ-016 At frame boundary, if pending=1 or load=1, active frame SHALL update; source = live inputs when load=1, else pending registers; pending SHALL clear that same edge.
REQ-017 Active frame SHALL never change outside a frame boundary (no tearing mid-scan).
REQ-018 an_out/c_out SHALL be registered: one cycle latency from digit index/active frame to pins.
REQ-019 For digit k enabled and display visible: an_out = ~(1<<k), c_out = ~active_c[7k+6:7k].
REQ-020 For digit k disabled: an_out = 8'hFF, c_out = 7'h7F; its dwell slot SHALL still be consumed (constant duty for other digits).
REQ-021 Blink frame counter SHALL count frame boundaries 0..BLINK_FRAMES-1 and toggle blink phase on wrap, only while blink_en=1.
REQ-022 blink_en=0 SHALL force phase visible and clear blink frame counter on next edge.
REQ-023 Blink phase hidden SHALL force an_out = 8'hFF, c_out = 7'h7F; scan counters continue.
REQ-024 All counters SHALL wrap silently; no overflow flag.

Reset
REQ-025 Reset SHALL clear: dwell counter 0, digit index 0, active and pending frames 0, pending 0, frame_done 0, blink counter 0, phase visible.
REQ-026 Reset SHALL drive an_out = 8'hFF, c_out = 7'h7F immediately (asynchronous).
REQ-027 Reset mid-scan SHALL discard any pending frame; first post-reset frame_done SHALL occur 8*DWELL_CYCLES cycles after release.

Structure
REQ-028 Shared package seg_scan_pkg SHALL hold NUM_DIGITS=8, SEG_W=7, FRAME_W=56, ANODES_OFF=8'hFF, SEGS_OFF=7'h7F and the 0-9 segment encoding table used by game logic.
REQ-029 One sub-module SHALL be natural: seg_dwell_timer (dwell counter + digit index + frame_done); everything else inline.

Verification (DWELL_CYCLES=4, BLINK_FRAMES=2)
REQ-030 Release reset, no load -> an_out=8'hFF, c_out=7'h7F all cycles; frame_done every 32 cycles, first at cycle 32.
REQ-031 load with an_in=8'b10000001, digit7=7'b0111111, digit0=7'b0000110 -> pending=1 until next boundary; next frame an_out=8'hFE/c_out=7'b1111001 for 4 cycles, 8'hFF in slots 1-6, 8'h7F/c_out=7'b1000000 in slot 7.
REQ-032 Two loads (frames A then B) within one frame -> only B ever displayed; A never appears on pins.
REQ-033 load asserted on boundary cycle with pending=1 -> live inputs displayed next frame, pending=0.
REQ-034 blink_en=1 with full frame loaded -> 2 frames visible, 2 frames all-off, repeating; blink_en=0 -> visible on next frame.
REQ-035 reset asserted at digit 3 with pending=1 -> outputs off same cycle, pending=0, active frame zero after release.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared constants and segment helpers for the multiplexed seven-segment scanner.
package seg_scan_pkg;

  localparam int NUM_DIGITS  = 8;
  localparam int SEG_W       = 7;
  localparam int FRAME_W     = NUM_DIGITS * SEG_W;
  localparam int DIGIT_IDX_W = 3;

  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 8'hFF;
  localparam logic [SEG_W-1:0]      SEGS_OFF   = 7'h7F;

  // One packed view of a whole frame so a digit can be picked by index.
  typedef logic [NUM_DIGITS-1:0][SEG_W-1:0] frame_t;

  // Blink phase of the whole display.
  typedef enum logic {
    PHASE_VISIBLE = 1'b0,
    PHASE_HIDDEN  = 1'b1
  } blink_phase_e;

  // Decimal digit patterns, bit order {g,f,e,d,c,b,a}, 1 = lit; entry 0 is digit 0.
  localparam logic [9:0][SEG_W-1:0] SEG_DIGITS = {
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  // Encode a decimal value for game logic; values above 9 render blank.
  function automatic logic [SEG_W-1:0] segEncode(input logic [3:0] value);
    logic [SEG_W-1:0] segs;
    segs = '0;
    if (value <= 4'd9) begin
      segs = SEG_DIGITS[value];
    end
    return segs;
  endfunction

endpackage

// File: rtl/seg_dwell_timer.sv
// Dwell counter and digit index for the scanner; flags the last cycle of each frame.
module seg_dwell_timer
  import seg_scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 4
) (
  input  logic                   newclock,
  input  logic                   reset,
  output logic [DIGIT_IDX_W-1:0] digit_idx_o,
  output logic                   frame_done_o
);

  localparam logic [7:0]             DWELL_LAST = 8'(DWELL_CYCLES - 1);
  localparam logic [DIGIT_IDX_W-1:0] DIGIT_LAST = DIGIT_IDX_W'(NUM_DIGITS - 1);

  logic [7:0]             dwellCnt_q, dwellCnt_d;
  logic [DIGIT_IDX_W-1:0] digitIdx_q, digitIdx_d;

  // Advance the dwell count each cycle and step to the next digit when it wraps.
  always_comb begin
    dwellCnt_d = dwellCnt_q + 8'd1;
    digitIdx_d = digitIdx_q;
    if (dwellCnt_q == DWELL_LAST) begin
      dwellCnt_d = '0;
      digitIdx_d = digitIdx_q + DIGIT_IDX_W'(1);
    end
  end

  // Scan position registers.
  always_ff @(posedge newclock or posedge reset) begin
    if (reset) begin
      dwellCnt_q <= '0;
      digitIdx_q <= '0;
    end else begin
      dwellCnt_q <= dwellCnt_d;
      digitIdx_q <= digitIdx_d;
    end
  end

  assign digit_idx_o  = digitIdx_q;
  assign frame_done_o = (dwellCnt_q == DWELL_LAST) && (digitIdx_q == DIGIT_LAST);

endmodule

// File: rtl/seg_frame_scanner.sv
// Eight-digit seven-segment scanner with tear-free double-buffered frames and whole-display blink.
module seg_frame_scanner
  import seg_scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter int BLINK_FRAMES = 8
) (
  input  logic                  newclock,
  input  logic                  reset,
  input  logic [NUM_DIGITS-1:0] an_in,
  input  logic [FRAME_W-1:0]    c_in,
  input  logic                  load,
  input  logic                  blink_en,
  output logic [NUM_DIGITS-1:0] an_out,
  output logic [SEG_W-1:0]      c_out,
  output logic                  pending,
  output logic                  frame_done
);

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [DIGIT_IDX_W-1:0] digitIdx;
  logic                   frameEnd;

  logic [NUM_DIGITS-1:0] pendAn_q, pendAn_d;
  frame_t                pendC_q, pendC_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] actAn_q, actAn_d;
  frame_t                actC_q, actC_d;
  logic [7:0]            blinkCnt_q, blinkCnt_d;
  blink_phase_e          phase_q, phase_d;
  logic [NUM_DIGITS-1:0] anOut_q, anOut_d;
  logic [SEG_W-1:0]      cOut_q, cOut_d;

  seg_dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .newclock    (newclock),
    .reset       (reset),
    .digit_idx_o (digitIdx),
    .frame_done_o(frameEnd)
  );

  // Capture loads into the pending buffer and swap into the active frame only at frame end.
  always_comb begin
    pendAn_d  = pendAn_q;
    pendC_d   = pendC_q;
    pending_d = pending_q;
    actAn_d   = actAn_q;
    actC_d    = actC_q;
    if (load) begin
      pendAn_d  = an_in;
      pendC_d   = c_in;
      pending_d = 1'b1;
    end
    if (frameEnd) begin
      pending_d = 1'b0;
      if (load) begin
        actAn_d = an_in;
        actC_d  = c_in;
      end else if (pending_q) begin
        actAn_d = pendAn_q;
        actC_d  = pendC_q;
      end
    end
  end

  // Frame buffer registers.
  always_ff @(posedge newclock or posedge reset) begin
    if (reset) begin
      pendAn_q  <= '0;
      pendC_q   <= '0;
      pending_q <= 1'b0;
      actAn_q   <= '0;
      actC_q    <= '0;
    end else begin
      pendAn_q  <= pendAn_d;
      pendC_q   <= pendC_d;
      pending_q <= pending_d;
      actAn_q   <= actAn_d;
      actC_q    <= actC_d;
    end
  end

  // Blink phase: count whole frames while blinking and flip phase each time the count wraps.
  always_comb begin
    phase_d    = phase_q;
    blinkCnt_d = blinkCnt_q;
    if (!blink_en) begin
      phase_d    = PHASE_VISIBLE;
      blinkCnt_d = '0;
    end else if (frameEnd) begin
      if (blinkCnt_q == BLINK_LAST) begin
        blinkCnt_d = '0;
        phase_d    = (phase_q == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
      end else begin
        blinkCnt_d = blinkCnt_q + 8'd1;
      end
    end
  end

  // Blink state registers.
  always_ff @(posedge newclock or posedge reset) begin
    if (reset) begin
      phase_q    <= PHASE_VISIBLE;
      blinkCnt_q <= '0;
    end else begin
      phase_q    <= phase_d;
      blinkCnt_q <= blinkCnt_d;
    end
  end

  // Pin values for the current digit; disabled digits and the hidden phase drive everything off.
  always_comb begin
    anOut_d = ANODES_OFF;
    cOut_d  = SEGS_OFF;
    if ((phase_q == PHASE_VISIBLE) && actAn_q[digitIdx]) begin
      anOut_d = ~(NUM_DIGITS'(1) << digitIdx);
      cOut_d  = ~actC_q[digitIdx];
    end
  end

  // Registered pin drivers, forced off the moment reset asserts.
  always_ff @(posedge newclock or posedge reset) begin
    if (reset) begin
      anOut_q <= ANODES_OFF;
      cOut_q  <= SEGS_OFF;
    end else begin
      anOut_q <= anOut_d;
      cOut_q  <= cOut_d;
    end
  end

  assign an_out     = anOut_q;
  assign c_out      = cOut_q;
  assign pending    = pending_q;
  assign frame_done = frameEnd;

endmodule

// File: tb/tb_seg_frame_scanner.sv
// Scoreboard bench for seg_frame_scanner with DWELL_CYCLES=4, BLINK_FRAMES=2.
module tb_seg_frame_scanner;

  localparam int DW = 4;
  localparam int BF = 2;
  localparam int FRAME_CYCLES = 8 * DW;

  logic        newclock;
  logic        reset;
  logic [7:0]  an_in;
  logic [55:0] c_in;
  logic        load;
  logic        blink_en;
  logic [7:0]  an_out;
  logic [6:0]  c_out;
  logic        pending;
  logic        frame_done;

  seg_frame_scanner #(
    .DWELL_CYCLES(DW),
    .BLINK_FRAMES(BF)
  ) dut (
    .newclock  (newclock),
    .reset     (reset),
    .an_in     (an_in),
    .c_in      (c_in),
    .load      (load),
    .blink_en  (blink_en),
    .an_out    (an_out),
    .c_out     (c_out),
    .pending   (pending),
    .frame_done(frame_done)
  );

  initial begin
    newclock = 1'b0;
    forever #5 newclock = ~newclock;
  end

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] c;
    logic       pend;
    logic       fd;
  } expect_t;

  expect_t expQ[$];

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state, expressed as the current cycle's position within a frame.
  int          mSlot;
  logic [7:0]  mActAn, mPendAn;
  logic [55:0] mActC, mPendC;
  bit          mPend;
  bit          mHidden;
  int          mBlinkCnt;

  bit watchA;
  bit sawA;

  // Compare one observed value against its expected value and report mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic resetModel();
    mSlot     = 0;
    mActAn    = '0;
    mActC     = '0;
    mPendAn   = '0;
    mPendC    = '0;
    mPend     = 1'b0;
    mHidden   = 1'b0;
    mBlinkCnt = 0;
  endtask

  // Drive one cycle of inputs at the falling edge, predict the next pin state, compare after the rising edge.
  task automatic applyStimulus(input logic ld, input logic [7:0] an, input logic [55:0] c);
    int         digit;
    bit         lit;
    bit         boundary;
    expect_t    e;
    expect_t    got;
    logic [7:0] oldPendAn;
    logic [55:0] oldPendC;

    load  = ld;
    an_in = an;
    c_in  = c;

    digit    = mSlot / DW;
    lit      = !mHidden && mActAn[digit];
    e.an     = lit ? ~(8'b1 << digit) : 8'hFF;
    e.c      = lit ? ~mActC[digit*7 +: 7] : 7'h7F;
    boundary = (mSlot == FRAME_CYCLES - 1);

    oldPendAn = mPendAn;
    oldPendC  = mPendC;
    if (ld) begin
      mPendAn = an;
      mPendC  = c;
    end
    if (boundary) begin
      if (ld) begin
        mActAn = an;
        mActC  = c;
      end else if (mPend) begin
        mActAn = oldPendAn;
        mActC  = oldPendC;
      end
      mPend = 1'b0;
    end else if (ld) begin
      mPend = 1'b1;
    end

    if (!blink_en) begin
      mBlinkCnt = 0;
      mHidden   = 1'b0;
    end else if (boundary) begin
      if (mBlinkCnt == BF - 1) begin
        mBlinkCnt = 0;
        mHidden   = !mHidden;
      end else begin
        mBlinkCnt++;
      end
    end

    mSlot  = (mSlot + 1) % FRAME_CYCLES;
    e.pend = mPend;
    e.fd   = (mSlot == FRAME_CYCLES - 1);
    expQ.push_back(e);

    @(posedge newclock);
    #1;
    if (expQ.size() == 0) begin
      checkOutput("queueEmpty", 64'd1, 64'd0);
    end else begin
      got = expQ.pop_front();
      checkOutput("an_out", 64'(an_out), 64'(got.an));
      checkOutput("c_out", 64'(c_out), 64'(got.c));
      checkOutput("pending", 64'(pending), 64'(got.pend));
      checkOutput("frame_done", 64'(frame_done), 64'(got.fd));
    end
    if (watchA && an_out == 8'hFB) begin
      sawA = 1'b1;
    end
    @(negedge newclock);
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 8'h00, 56'h0);
    end
  endtask

  task automatic runUntilSlot(input int target);
    for (int i = 0; i < FRAME_CYCLES && mSlot != target; i++) begin
      applyStimulus(1'b0, 8'h00, 56'h0);
    end
  endtask

  // Count cycles from reset release to the first frame_done, bounded to two frames.
  task automatic checkFirstFrameDone(input string tag);
    int n;
    n = 0;
    for (int i = 1; i <= 2 * FRAME_CYCLES; i++) begin
      applyStimulus(1'b0, 8'h00, 56'h0);
      if (frame_done && n == 0) n = i + 1;
    end
    checkOutput(tag, 64'(n), 64'(FRAME_CYCLES));
  endtask

  logic [55:0] frameA, frameB, frameX, frameY, frameFull, frame031;

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    blink_en = 1'b0;
    an_in    = '0;
    c_in     = '0;
    watchA   = 1'b0;
    sawA     = 1'b0;
    resetModel();

    frame031  = {7'b0111111, 42'h0, 7'b0000110};
    frameA    = {35'h0, 7'b1110110, 14'h0};
    frameB    = {21'h0, 7'b1011011, 28'h0};
    frameX    = 56'h0123_4567_89AB_CD;
    frameY    = 56'hFEDC_BA98_7654_32;
    frameFull = {7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
                 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111};

    @(negedge newclock);
    @(negedge newclock);
    checkOutput("resetAn", 64'(an_out), 64'h0FF);
    checkOutput("resetC", 64'(c_out), 64'h07F);
    checkOutput("resetPending", 64'(pending), 64'd0);
    checkOutput("resetFrameDone", 64'(frame_done), 64'd0);
    reset = 1'b0;
    $display("[TB] reset released");

    // Idle display: everything off, frame_done first at cycle 32 then every 32.
    checkFirstFrameDone("firstFrameDone");

    // Two-digit frame loaded mid-scan, shown from the next frame.
    runUntilSlot(9);
    applyStimulus(1'b1, 8'b1000_0001, frame031);
    runIdle(FRAME_CYCLES + 40);

    // Frame A overwritten by frame B before any boundary; A must never reach the pins.
    runUntilSlot(3);
    watchA = 1'b1;
    applyStimulus(1'b1, 8'b0000_0100, frameA);
    runIdle(5);
    applyStimulus(1'b1, 8'b0001_0000, frameB);
    runIdle(2 * FRAME_CYCLES);
    watchA = 1'b0;
    checkOutput("frameANeverShown", 64'(sawA), 64'd0);

    // Load on the boundary cycle while a frame is pending: live inputs win.
    runUntilSlot(6);
    applyStimulus(1'b1, 8'h0F, frameX);
    runUntilSlot(FRAME_CYCLES - 1);
    applyStimulus(1'b1, 8'hF0, frameY);
    runIdle(FRAME_CYCLES + 8);

    // Blink a full frame: two frames on, two off, then visible again once disabled.
    runUntilSlot(2);
    applyStimulus(1'b1, 8'hFF, frameFull);
    runUntilSlot(0);
    blink_en = 1'b1;
    runIdle(6 * FRAME_CYCLES);
    blink_en = 1'b0;
    runIdle(2 * FRAME_CYCLES);

    // Reset at digit 3 with a frame pending.
    runUntilSlot(1);
    applyStimulus(1'b1, 8'hAA, frameX);
    runUntilSlot(13);
    reset = 1'b1;
    #1;
    checkOutput("midResetAn", 64'(an_out), 64'h0FF);
    checkOutput("midResetC", 64'(c_out), 64'h07F);
    checkOutput("midResetPending", 64'(pending), 64'd0);
    @(posedge newclock);
    @(negedge newclock);
    reset = 1'b0;
    resetModel();
    checkFirstFrameDone("postResetFrameDone");
    runIdle(FRAME_CYCLES);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
